// File: rtl/zrld.sv
// Zero-run-length decoder: unpacks '1' / '0'+k symbols into one zero/non-zero flag per handshake.
// Optional sticky format-error output enabled by defining ZRLD_ERR_CHECK_EN.
module zrld #(
  parameter int DATA_W           = 8,
  parameter int LOG_MAX_ZRLE_LEN = 4,
  parameter int MAX_ZRLE_LEN     = 16,
  parameter int CNT_W            = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic              is_one_o,
  output logic              flush_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o,
  output logic              err_o
);

  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int RUN_W  = LOG_MAX_ZRLE_LEN + 1;

  localparam logic [FILL_W-1:0] ONE_BITS  = FILL_W'(1);
  localparam logic [FILL_W-1:0] ZERO_BITS = FILL_W'(1 + LOG_MAX_ZRLE_LEN);
  localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic                  last_seen_q, last_seen_d;

  logic                        sym_one, sym_zero, run_pend, dec_vld;
  logic                        out_fire, in_fire, final_fire;
  logic [FILL_W-1:0]           consume, fill_after;
  logic [LOG_MAX_ZRLE_LEN-1:0] run_k;
  logic [BUF_W-1:0]            word_al, buf_app;

  assign run_pend = (run_q != '0);
  assign sym_one  = (fill_q >= ONE_BITS) & buf_q[BUF_W-1];
  assign sym_zero = (fill_q >= ZERO_BITS) & ~buf_q[BUF_W-1];
  assign dec_vld  = run_pend | sym_one | sym_zero;
  assign run_k    = buf_q[BUF_W-2 -: LOG_MAX_ZRLE_LEN];

  assign out_fire   = (state_q == DECODE) & dec_vld & rdy_i;
  assign final_fire = out_fire & (rem_q == CNT_W'(1));
  assign consume    = (out_fire & ~run_pend) ? (sym_one ? ONE_BITS : ZERO_BITS) : '0;
  assign fill_after = fill_q - consume;
  assign in_fire    = vld_i & rdy_o;

  // Incoming word lands directly behind whatever survives this cycle's consumption.
  assign word_al = {data_i, {DATA_W{1'b0}}};
  assign buf_app = (buf_q << consume) |
                   (((state_q == DECODE) & in_fire) ? (word_al >> fill_after) : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      rem_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      rem_q       <= rem_d;
      last_seen_q <= last_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    run_d       = run_q;
    rem_d       = rem_q;
    last_seen_d = last_seen_q;
    case (state_q)
      IDLE: begin
        if (vld_i) begin
          buf_d       = word_al;
          fill_d      = WORD_BITS;
          run_d       = '0;
          rem_d       = cnt_i;
          last_seen_d = last_i;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        buf_d  = buf_app;
        fill_d = fill_after + (in_fire ? WORD_BITS : '0);
        if (in_fire) last_seen_d = last_i;
        if (out_fire) begin
          rem_d = rem_q - CNT_W'(1);
          if (run_pend)      run_d = run_q - RUN_W'(1);
          else if (!sym_one) run_d = {1'b0, run_k};
        end
        // Stream is complete by count: anything still buffered or pending is dropped.
        if (final_fire) begin
          buf_d   = '0;
          fill_d  = '0;
          run_d   = '0;
          state_d = (last_seen_q | (in_fire & last_i)) ? IDLE : DISCARD;
        end
      end
      DISCARD: begin
        if (vld_i & last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_o    = 1'b0;
    idle_o   = 1'b0;
    vld_o    = 1'b0;
    is_one_o = 1'b0;
    flush_o  = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_o  = 1'b1;
        idle_o = ~vld_i;
      end
      DECODE: begin
        vld_o    = dec_vld;
        is_one_o = ~run_pend & sym_one;
        flush_o  = dec_vld & (rem_q == CNT_W'(1));
        rdy_o    = ~last_seen_q & (fill_after <= WORD_BITS);
      end
      DISCARD: begin
        rdy_o = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ZRLD_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == DECODE) & last_seen_q & ~dec_vld) err_d = 1'b1;
    if (final_fire & (buf_app != '0))                 err_d = 1'b1;
    if ((state_q == DISCARD) & vld_i & (data_i != '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Waiting for bits after the final word means the encoder produced fewer symbols than cnt_i.
  a_truncated: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((state_q == DECODE) && last_seen_q && !dec_vld && (fill_q != '0)));

  a_run_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_fire && !run_pend && !sym_one) |-> (32'(run_k) < MAX_ZRLE_LEN));

endmodule

// File: tb/tb_zrld.sv
// Directed bench for zrld: hand-computed flag sequences, stalls, count mismatch, discard and reset.
module tb_zrld;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  data_i;
  logic        last_i;
  logic        vld_i;
  logic        rdy_o;
  logic [15:0] cnt_i;
  logic        is_one_o;
  logic        flush_o;
  logic        vld_o;
  logic        rdy_i;
  logic        idle_o;
  logic        err_o;

  int n_chk = 0;
  int n_err = 0;

`ifdef ZRLD_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  zrld dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .data_i   (data_i),
    .last_i   (last_i),
    .vld_i    (vld_i),
    .rdy_o    (rdy_o),
    .cnt_i    (cnt_i),
    .is_one_o (is_one_o),
    .flush_o  (flush_o),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i),
    .idle_o   (idle_o),
    .err_o    (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Feeds up to three words and checks each flag handshake against exp_f (bit i = flag i).
  task automatic run_stream(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int nw, input int cnt, input logic [31:0] exp_f,
                            input int nf, input bit tog);
    int   wi = 0;
    int   fi = 0;
    int   bub = 0;
    logic p_stall = 1'b0;
    logic p_one = 1'b0;
    logic p_fl = 1'b0;
    bit   rdy_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !(fi == nf && wi == nw); cyc++) begin
      @(negedge clk_i);
      vld_i  = (wi < nw);
      data_i = (wi == 0) ? w0 : ((wi == 1) ? w1 : w2);
      last_i = (wi == nw - 1);
      cnt_i  = 16'(cnt);
      rdy_i  = tog ? cyc[0] : 1'b1;
      #1;
      if (p_stall) begin
        chk("stall_vld", vld_o, 1);
        chk("stall_one", is_one_o, p_one);
        chk("stall_flush", flush_o, p_fl);
      end
      if (wi == 1 && vld_i && !rdy_seen) begin
        rdy_seen = 1'b1;
        chk("rdy_word2", rdy_o, 1);
      end
      if (vld_o && rdy_i) begin
        chk($sformatf("flag%0d", fi), is_one_o, exp_f[fi]);
        chk($sformatf("flush%0d", fi), flush_o, (fi == nf - 1));
        fi++;
      end else if (fi > 0 && fi < nf && !vld_o) begin
        bub++;
      end
      p_stall = vld_o && !rdy_i;
      p_one   = is_one_o;
      p_fl    = flush_o;
      if (vld_i && rdy_o) wi++;
    end
    chk("flags_done", fi, nf);
    chk("words_done", wi, nw);
    chk("bubbles", bub, 0);
    @(negedge clk_i);
    vld_i  = 1'b0;
    last_i = 1'b0;
    rdy_i  = 1'b1;
    #1;
    chk("idle_after", idle_o, 1);
    chk("vld_after", vld_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    data_i = '0;
    last_i = 1'b0;
    vld_i  = 1'b0;
    cnt_i  = '0;
    rdy_i  = 1'b0;
    #1;
    chk("rst_vld", vld_o, 0);
    chk("rst_one", is_one_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_rdy", rdy_o, 1);
    chk("rst_err", err_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // 1,1,0,0,0,1
    run_stream(8'hC5, 8'h00, 8'h00, 1, 6, 32'h23, 6, 1'b0);
    // sixteen zeros, padding dropped
    run_stream(8'h78, 8'h00, 8'h00, 1, 16, 32'h0, 16, 1'b0);
    chk("err_clean16", err_o, 0);
    // symbol straddling two words: six 1s, five 0s, one 1
    run_stream(8'hFC, 8'h90, 8'h00, 2, 12, 32'h83F, 12, 1'b0);
    chk("err_clean_straddle", err_o, 0);
    // downstream backpressure every other cycle
    run_stream(8'hC5, 8'h00, 8'h00, 1, 6, 32'h23, 6, 1'b1);
    // count shorter than encoded stream: pending run and a '1' bit dropped
    run_stream(8'hC5, 8'h00, 8'h00, 1, 4, 32'h3, 4, 1'b0);
    chk("err_count", err_o, ERR_EN);
    run_stream(8'hC5, 8'h00, 8'h00, 1, 6, 32'h23, 6, 1'b0);
    // count ends before the last word arrives: third word goes through DISCARD
    run_stream(8'hFF, 8'hFF, 8'h00, 3, 2, 32'h3, 2, 1'b0);

    // reset in the middle of an 11-zero run
    @(negedge clk_i);
    vld_i  = 1'b1;
    data_i = 8'h50;
    last_i = 1'b1;
    cnt_i  = 16'd11;
    rdy_i  = 1'b1;
    @(negedge clk_i);
    vld_i  = 1'b0;
    last_i = 1'b0;
    #1;
    chk("run_first_vld", vld_o, 1);
    chk("run_first_zero", is_one_o, 0);
    @(negedge clk_i);
    #1;
    chk("run_mid_vld", vld_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_vld", vld_o, 0);
    chk("midrst_idle", idle_o, 1);
    chk("midrst_err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_stream(8'hC5, 8'h00, 8'h00, 1, 6, 32'h23, 6, 1'b0);
    chk("err_final", err_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/zrld.md
Name: zrld

Overview:
- Zero-run-length decoder on the EBPC decompression path.
- Consumes the packed DATA_W-bit word stream produced by the ZRLE encoder stage.
- Emits one zero/non-zero flag per handshake to the downstream value-reassembly stage, flagging the final one.
- Inverse of the encoder bit format:
  - '1' = one non-zero item.
  - '0' followed by LOG_MAX_ZRLE_LEN bits k = run of k+1 zeros.
  - Fields are packed MSB-first; the last word is zero-padded.

Parameters:
DATA_W, 8, packed word width
LOG_MAX_ZRLE_LEN, 4, run-length field width
MAX_ZRLE_LEN, 16, maximum run (must be <= 2**LOG_MAX_ZRLE_LEN)
CNT_W, 16, width of flag-count input

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_i  in  DATA_W  packed word, MSB first
last_i  in  1  final word of stream
vld_i  in  1  input valid
rdy_o  out  1  input ready
cnt_i  in  CNT_W  number of flags in stream (>=1), sampled with first word
is_one_o  out  1  decoded flag, 1 = non-zero item
flush_o  out  1  marks final flag of stream
vld_o  out  1  output valid
rdy_i  in  1  output ready
idle_o  out  1  no stream in progress
err_o  out  1  sticky format error (see Optional Feature)

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
- Reset values: state IDLE; all registers 0; vld_o=0, is_one_o=0, flush_o=0, err_o=0, idle_o=1, rdy_o=1.
- Registers:
  - buf_q: 2*DATA_W, left-aligned.
  - fill_q: 0..2*DATA_W.
  - run_q: pending zeros, LOG_MAX_ZRLE_LEN+1 bits.
  - rem_q: flags still to emit, CNT_W.
  - last_seen_q.
- States: IDLE, DECODE, DISCARD.
- IDLE:
  - rdy_o=1.
  - On vld_i: load word into buf top, fill=DATA_W, rem=cnt_i, last_seen=last_i, go to DECODE.
  - idle_o=1 only when not vld_i.
- DECODE output selection, in priority order:
  1. run_q!=0: vld_o=1, is_one_o=0; on rdy_i, run_q-1.
  2. Else fill_q>=1 and buf MSB=1: vld_o=1, is_one_o=1; on rdy_i, consume 1 bit.
  3. Else fill_q>=1+LOG_MAX_ZRLE_LEN, MSB=0: vld_o=1, is_one_o=0; on rdy_i, consume 1+LOG_MAX_ZRLE_LEN bits, run_q=k (the k+1 zeros count the current one).
  4. Else vld_o=0 (waiting for bits).
- Zero latency: the first flag is visible the cycle after the first word is accepted; one flag per cycle at full throughput.
- Every output handshake decrements rem_q. flush_o = vld_o & (rem_q==1).
- Input in DECODE:
  - rdy_o = !last_seen_q & (fill_after_consume <= DATA_W), where fill_after_consume includes the same-cycle consumption.
  - The new word is ORed in at bit position fill_after_consume.
  - Simultaneous consume and append in one cycle is required.
- Final flag handshake (rem_q reaches 0):
  - Clear buf, fill and run, including any unfinished run.
  - If last_seen: go to IDLE.
  - Else: go to DISCARD.
- DISCARD: rdy_o=1; accept and drop words; on last_i handshake, go to IDLE.
- Outputs hold stable while vld_o & !rdy_i.
- Reset mid-stream: everything returns to the reset state; the partial stream is lost.
- Simulation assertion: in DECODE, last_seen, waiting state (case 4) and fill_q>0 means a truncated stream.

Optional Feature:
- Macro: ZRLD_ERR_CHECK_EN.
- Defined: err_o is set (sticky until reset) on either of:
  - a truncated stream (last word consumed, rem_q>0, no decodable symbol);
  - non-zero bits discarded at the final flag or in DISCARD.
- Undefined: err_o tied 0, no check logic.

Test Plan:
- Flags 1,1,0,0,0,1 → word 0xC5 last, cnt_i=6 → is_one 1,1,0,0,0,1 on 6 consecutive cycles; flush_o only on the 6th; then idle_o=1.
- 16 zeros → word 0x78 last, cnt_i=16 → 16 zero flags, flush_o on the 16th; padding discarded, err_o=0.
- Straddling symbol: words 0xFC, 0x90(last), cnt_i=12 → six 1s, five 0s, one 1; rdy_o accepts 2nd word without a bubble.
- Backpressure: vector 1 with rdy_i toggling each cycle → identical flag sequence; is_one_o/flush_o stable while stalled.
- Count mismatch: vector 1 with cnt_i=4 → flags 1,1,0,0, flush on the 4th; remaining run dropped; with ZRLD_ERR_CHECK_EN err_o=1 (bit "1" discarded); next stream decodes correctly.
- Reset asserted mid-run (run_q=10) → vld_o=0, idle_o=1 immediately; fresh stream 0xC5 decodes correctly afterwards.
